// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
// Port indices select bits of the internal request/grant vectors.
package mem_arb_pkg;

   localparam int PORT_INST = 0;
   localparam int PORT_DATA = 1;

   localparam int BURST_W = 4;

   // Value replicated onto mem_addr / mem_wdata when nothing is granted
   localparam logic IDLE_ADDR_FILL  = 1'b0;
   localparam logic IDLE_WDATA_FILL = 1'b0;

   typedef struct packed {
      logic rd_inst;
      logic rd_data;
   } pend_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory signals seen by the arbiter.
// Handshake: a requester holds req and its payload stable until gnt is seen high in the
// same cycle; gnt is the acceptance, reads return with rvalid exactly one cycle later.
interface mem_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
);

   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_gnt;
   logic                  i_rvalid;
   logic [DATA_WIDTH-1:0] i_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_WIDTH-1:0] d_rdata;

   logic                  mem_request;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // System side: the two requesters plus the memory's read data
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_request, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_request, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data requests, with a burst counter that
// hands the memory to fetch after MAX_BURST consecutive data grants.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

   logic [BURST_W-1:0] r_burst_cnt;
   logic               w_fetch_turn;
   logic               w_data_gnt;
   logic               w_inst_gnt;

   assign w_fetch_turn = i_req[PORT_INST] && (r_burst_cnt == MAX_CNT);
   assign w_data_gnt   = rst_n && i_req[PORT_DATA] && !w_fetch_turn;
   assign w_inst_gnt   = rst_n && i_req[PORT_INST] && !w_data_gnt;

   always_comb begin
      o_gnt            = '0;
      o_gnt[PORT_INST] = w_inst_gnt;
      o_gnt[PORT_DATA] = w_data_gnt;
   end

   // Counts only data grants that made a waiting fetch wait longer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_burst_cnt <= '0;
      end else if (!i_req[PORT_INST] || w_inst_gnt) begin
         r_burst_cnt <= '0;
      end else if (w_data_gnt && (r_burst_cnt != MAX_CNT)) begin
         r_burst_cnt <= r_burst_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports:
// steers the granted request to memory and routes read data back to its issuer.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7,
   parameter int MAX_BURST  = 4
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);

   logic [1:0]            w_req;
   logic [1:0]            w_gnt;
   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_wdata;

   pend_t                 r_pend;
   logic [DATA_WIDTH-1:0] r_hold_inst;
   logic [DATA_WIDTH-1:0] r_hold_data;

   always_comb begin
      w_req            = '0;
      w_req[PORT_INST] = bus.i_req;
      w_req[PORT_DATA] = bus.d_req;
   end

   mem_arb_prio #(
      .MAX_BURST(MAX_BURST)
   ) u_prio (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (w_req),
      .o_gnt (w_gnt)
   );

   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = {ADDR_WIDTH{IDLE_ADDR_FILL}};
      w_mem_wdata = {DATA_WIDTH{IDLE_WDATA_FILL}};
      if (w_gnt[PORT_DATA]) begin
         w_mem_we    = bus.d_we;
         w_mem_addr  = bus.d_addr;
         w_mem_wdata = bus.d_wdata;
      end else if (w_gnt[PORT_INST]) begin
         w_mem_addr  = bus.i_addr;
      end
   end

   assign bus.i_gnt       = w_gnt[PORT_INST];
   assign bus.d_gnt       = w_gnt[PORT_DATA];
   assign bus.mem_request = w_gnt[PORT_INST] | w_gnt[PORT_DATA];
   assign bus.mem_we      = w_mem_we;
   assign bus.mem_addr    = w_mem_addr;
   assign bus.mem_wdata   = w_mem_wdata;

   // Gating with rst_n drops a response whose read was granted just before reset
   assign bus.i_rvalid = rst_n && r_pend.rd_inst;
   assign bus.d_rvalid = rst_n && r_pend.rd_data;
   assign bus.i_rdata  = !rst_n ? '0 : (r_pend.rd_inst ? bus.mem_rdata : r_hold_inst);
   assign bus.d_rdata  = !rst_n ? '0 : (r_pend.rd_data ? bus.mem_rdata : r_hold_data);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pend      <= '0;
         r_hold_inst <= '0;
         r_hold_data <= '0;
      end else begin
         r_pend.rd_inst <= w_gnt[PORT_INST];
         r_pend.rd_data <= w_gnt[PORT_DATA] && !bus.d_we;
         if (r_pend.rd_inst) begin
            r_hold_inst <= bus.mem_rdata;
         end
         if (r_pend.rd_data) begin
            r_hold_data <= bus.mem_rdata;
         end
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter placed between the core's instruction-fetch port and data load/store port and one shared single-port synchronous memory (1-cycle read latency, request/we/addr/data_i/data_o interface). Each cycle it grants at most one requester, steers address, write data and write-enable to the memory, and returns read data to the port that issued the read. Data accesses have priority; a burst limiter guarantees fetch forward progress.

## Interface
- DATA_WIDTH, 32: word width.
- ADDR_WIDTH, 7: word address width.
- MAX_BURST, 4: max consecutive data grants while fetch is waiting; legal 1..15.

- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_req  in  1  fetch port request (read-only port).
- i_addr  in  ADDR_WIDTH  fetch word address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  DATA_WIDTH  fetch read data.
- d_req  in  1  data port request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data word address.
- d_wdata  in  DATA_WIDTH  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_WIDTH  load data.
- mem_request  out  1  to memory request.
- mem_we  out  1  to memory write enable.
- mem_addr  out  ADDR_WIDTH  to memory address.
- mem_wdata  out  DATA_WIDTH  to memory write data.
- mem_rdata  in  DATA_WIDTH  from memory, valid the cycle after a read request.

## Operation
- Requester holds req and its payload stable until it sees gnt in the same cycle; gnt is combinational from req and internal state.
- Grant rule: only one req → grant it. Both req → grant data, unless burst counter == MAX_BURST, then grant fetch.
- Burst counter (4 bits): increments on each data grant while i_req=1; clears on a fetch grant or any cycle with i_req=0; saturates at MAX_BURST.
- Memory drive: mem_request = i_gnt | d_gnt. Fetch grant: mem_we=0, mem_addr=i_addr. Data grant: mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata. No grant: mem_we=0, mem_addr/mem_wdata = 0.
- Response tracking: 2-bit registered pending flag {rd_inst, rd_data}, set at grant of a read, consumed next cycle. Stores produce no rvalid; d_gnt is the store acknowledgement.
- x_rvalid = pending flag for that port; x_rdata = mem_rdata while x_rvalid, else last captured value for that port (per-port hold register, loaded on rvalid cycles).
- Arbiter is fully pipelined: a new grant may issue in the same cycle as a response to either port.

## Timing
- Grant in cycle T → memory samples at end of T → x_rvalid=1 and x_rdata valid in T+1.
- Back-to-back grants to one port at T, T+1 → rvalid at T+1, T+2 with data in order.
- Reset (any cycle, including with a read pending): all gnt=0 and mem_request=0 in the reset cycle; pending flags, burst counter, hold registers cleared; rvalid=0 and rdata=0 the cycle after reset; a read granted before reset never produces rvalid.
- Reset values: i_gnt, d_gnt, i_rvalid, d_rvalid, mem_request, mem_we = 0; i_rdata, d_rdata, mem_addr, mem_wdata = 0.
- Requests are ignored while rst_n=0.
- Memory garbage on non-read cycles (e.g. 0xDEADBEEF after store, 0x12345678 when idle) never reaches x_rdata.

## Structure
- Package mem_arb_pkg: port index constants PORT_INST=0, PORT_DATA=1; burst counter width constant (4); idle-drive constants for mem_addr/mem_wdata.
- One sub-module: mem_arb_prio — grant decision plus burst counter; top holds muxing, pending flags and hold registers.

## Test plan
- Fetch only, i_addr=0x05 with mem[5]=0x0000_0013 → i_gnt in T, i_rvalid=1 and i_rdata=0x0000_0013 in T+1; i_rdata holds 0x13 afterward while memory idles.
- Store then load: d_we=1, d_addr=0x10, d_wdata=0xCAFE_F00D, then d_we=0 same address → no d_rvalid after store; load gives d_rdata=0xCAFE_F00D one cycle after grant.
- Contention, MAX_BURST=4: i_req and d_req held high 12 cycles → grant pattern D,D,D,D,I,D,D,D,D,I,D,D; every response returns to the correct port.
- i_req drops for one cycle during a data burst → counter clears; next contention starts a fresh 4-grant data run.
- rst_n low in the cycle after a granted fetch read → i_rvalid stays 0, i_rdata=0, no grant during reset, normal operation on the first cycle after release.
- Alternating single-cycle requests (fetch T, data load T+1) → i_rvalid at T+1 and d_rvalid at T+2, never both asserted for the same memory response.
